// File: rtl/line_window_pkg.sv
// Shared types and constants for the line-buffer window controller.
// Pixels are held as packed words so a whole window travels as one vector.
package line_window_pkg;

   localparam int PIX_W   = 12;
   localparam int WIN_DIM = 3;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      STREAM,
      DONE
   } state_t;

   typedef logic [PIX_W-1:0] pixel_t;
   typedef pixel_t [WIN_DIM*WIN_DIM-1:0] window_t;

endpackage : line_window_pkg

// File: rtl/window_shift3.sv
// Three-column window shift register.
// Each enabled cycle the oldest column drops out and the new column lands at dx=2.
module window_shift3
   import line_window_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  pixel_t [WIN_DIM-1:0]      col,
   output window_t                   win
);

   // NOTE: non-blocking updates read pre-edge values, so the loop order cannot corrupt the shift.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win <= '0;
      end else if (en) begin
         for (int dy = 0; dy < WIN_DIM; dy++) begin
            for (int dx = 0; dx < WIN_DIM-1; dx++) begin
               win[dy*WIN_DIM+dx] <= win[dy*WIN_DIM+dx+1];
            end
            win[dy*WIN_DIM+WIN_DIM-1] <= col[dy];
         end
      end
   end

endmodule : window_shift3

// File: rtl/line_window_ctrl.sv
// Raster controller for two chained row buffers.
// It assembles a 3x3 window around each interior pixel and flags it one cycle after the accept.
module line_window_ctrl
   import line_window_pkg::*;
#(
   parameter int ROW_SIZE   = 1280,
   parameter int NUM_ROWS   = 960,
   parameter int PIXEL_SIZE = PIX_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic                          in_sof,
   input  logic [PIXEL_SIZE-1:0]         in_pixel,
   input  logic [PIXEL_SIZE-1:0]         rb0_out,
   input  logic [PIXEL_SIZE-1:0]         rb1_out,
   output logic                          rb_enable,
   output logic [PIXEL_SIZE-1:0]         rb_shiftin,
   output logic                          win_valid,
   output logic [9*PIXEL_SIZE-1:0]       win_pixels,
   output logic [$clog2(NUM_ROWS)-1:0]   win_row,
   output logic [$clog2(ROW_SIZE)-1:0]   win_col,
   output logic                          frame_done,
   output logic                          busy
);

   localparam int CW = $clog2(ROW_SIZE);
   localparam int RW = $clog2(NUM_ROWS);
   localparam logic [CW-1:0] LAST_COL = CW'(ROW_SIZE-1);
   localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROWS-1);

   state_t         state;
   logic [CW-1:0]  col;
   logic [RW-1:0]  row;
   logic [CW-1:0]  cur_col;
   logic [RW-1:0]  cur_row;
   logic           acc;
   logic           emit;
   logic           row_end;
   logic           frame_end;
   window_t        win;

   // A start-of-frame pixel is always (0,0), which is also how a mid-frame restart aborts.
   always_comb begin
      acc       = in_valid & (in_sof | (state == FILL) | (state == STREAM));
      cur_col   = in_sof ? '0 : col;
      cur_row   = in_sof ? '0 : row;
      row_end   = (cur_col == LAST_COL);
      frame_end = row_end && (cur_row == LAST_ROW);
      emit      = acc && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
   end

   assign rb_enable  = acc;
   assign rb_shiftin = in_pixel;
   assign busy       = (state == FILL) || (state == STREAM);
   assign win_pixels = win;

   window_shift3 u_shift (
      .clk (clk),
      .rst (rst),
      .en  (acc),
      .col ({in_pixel, rb0_out, rb1_out}),
      .win (win)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         col        <= '0;
         row        <= '0;
         win_valid  <= 1'b0;
         win_row    <= '0;
         win_col    <= '0;
         frame_done <= 1'b0;
      end else begin
         win_valid  <= emit;
         frame_done <= 1'b0;
         if (emit) begin
            win_row <= cur_row - 1'b1;
            win_col <= cur_col - 1'b1;
         end
         if (acc) begin
            col <= row_end ? '0 : cur_col + 1'b1;
            if (row_end) begin
               row <= frame_end ? '0 : cur_row + 1'b1;
            end else begin
               row <= cur_row;
            end
            if (frame_end) begin
               state      <= DONE;
               frame_done <= 1'b1;
            end else if (row_end && (cur_row == RW'(1))) begin
               state <= STREAM;
            end else if (in_sof) begin
               state <= FILL;
            end
         end
      end
   end

endmodule : line_window_ctrl

// File: tb/tb_line_window_ctrl.sv
// Directed bench for line_window_ctrl on an 8x4 frame with pixel = base + 8*row + col.
// The row buffers are modelled as a 16-deep shift chain clocked by rb_enable.
module tb_line_window_ctrl;

   localparam int RS = 8;
   localparam int NR = 4;
   localparam int PW = 12;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic                in_sof;
   logic [PW-1:0]       in_pixel;
   logic [PW-1:0]       rb0_out;
   logic [PW-1:0]       rb1_out;
   logic                rb_enable;
   logic [PW-1:0]       rb_shiftin;
   logic                win_valid;
   logic [9*PW-1:0]     win_pixels;
   logic [1:0]          win_row;
   logic [2:0]          win_col;
   logic                frame_done;
   logic                busy;

   int checks = 0;
   int errors = 0;
   int win_count = 0;

   logic [PW-1:0] hist [0:2*RS-1];

   typedef struct {
      logic          valid;
      logic          sof;
      logic [PW-1:0] pixel;
      logic          exp_en;
      logic          exp_busy;
   } vec_t;

   vec_t vecs [4];

   line_window_ctrl #(
      .ROW_SIZE   (RS),
      .NUM_ROWS   (NR),
      .PIXEL_SIZE (PW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_sof     (in_sof),
      .in_pixel   (in_pixel),
      .rb0_out    (rb0_out),
      .rb1_out    (rb1_out),
      .rb_enable  (rb_enable),
      .rb_shiftin (rb_shiftin),
      .win_valid  (win_valid),
      .win_pixels (win_pixels),
      .win_row    (win_row),
      .win_col    (win_col),
      .frame_done (frame_done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rb_enable) begin
         hist[0] <= in_pixel;
         for (int i = 1; i < 2*RS; i++) hist[i] <= hist[i-1];
      end
   end

   assign rb0_out = hist[RS-1];
   assign rb1_out = hist[2*RS-1];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One accepted pixel at frame position (r,c); checks the result one edge later.
   task automatic pix_cycle(input logic sof, input int base, input int r, input int c);
      logic [PW-1:0]   p;
      logic [9*PW-1:0] ew;
      logic            exp_win;
      p        = PW'(base + 8*r + c);
      in_valid = 1'b1;
      in_sof   = sof;
      in_pixel = p;
      #1;
      check("rb_enable", 128'(rb_enable), 128'(1));
      check("rb_shiftin", 128'(rb_shiftin), 128'(p));
      @(posedge clk);
      #1;
      exp_win = (r >= 2) && (c >= 2);
      check("win_valid", 128'(win_valid), 128'(exp_win));
      check("frame_done", 128'(frame_done), 128'((r == NR-1) && (c == RS-1)));
      if (exp_win) begin
         win_count++;
         for (int k = 0; k < 9; k++)
            ew[k*PW +: PW] = PW'(base + 8*(r-2+k/3) + (c-2+k%3));
         check("win_row", 128'(win_row), 128'(r-1));
         check("win_col", 128'(win_col), 128'(c-1));
         check("win_pixels", 128'(win_pixels), 128'(ew));
      end
   endtask

   task automatic idle_cycle();
      in_valid = 1'b0;
      in_sof   = 1'b0;
      #1;
      check("gap_rb_enable", 128'(rb_enable), 128'(0));
      @(posedge clk);
      #1;
      check("gap_win_valid", 128'(win_valid), 128'(0));
      check("gap_frame_done", 128'(frame_done), 128'(0));
   endtask

   task automatic run_frame(input int base, input int gap_max);
      win_count = 0;
      for (int r = 0; r < NR; r++) begin
         for (int c = 0; c < RS; c++) begin
            pix_cycle((r == 0) && (c == 0), base, r, c);
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) idle_cycle();
         end
      end
      check("window_count", 128'(win_count), 128'((RS-2)*(NR-2)));
      check("busy_done", 128'(busy), 128'(0));
   endtask

   task automatic run_table();
      for (int i = 0; i < 4; i++) begin
         in_valid = vecs[i].valid;
         in_sof   = vecs[i].sof;
         in_pixel = vecs[i].pixel;
         #1;
         check("tbl_rb_enable", 128'(rb_enable), 128'(vecs[i].exp_en));
         @(posedge clk);
         #1;
         check("tbl_busy", 128'(busy), 128'(vecs[i].exp_busy));
         check("tbl_win_valid", 128'(win_valid), 128'(0));
         check("tbl_frame_done", 128'(frame_done), 128'(0));
      end
   endtask

   initial begin
      vecs[0] = '{valid: 1'b1, sof: 1'b0, pixel: 12'd5, exp_en: 1'b0, exp_busy: 1'b0};
      vecs[1] = '{valid: 1'b1, sof: 1'b0, pixel: 12'd6, exp_en: 1'b0, exp_busy: 1'b0};
      vecs[2] = '{valid: 1'b0, sof: 1'b1, pixel: 12'd7, exp_en: 1'b0, exp_busy: 1'b0};
      vecs[3] = '{valid: 1'b0, sof: 1'b0, pixel: 12'd0, exp_en: 1'b0, exp_busy: 1'b0};

      rst      = 1'b1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_pixel = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_win_valid", 128'(win_valid), 128'(0));
      check("rst_win_pixels", 128'(win_pixels), 128'(0));
      check("rst_win_row", 128'(win_row), 128'(0));
      check("rst_win_col", 128'(win_col), 128'(0));
      check("rst_frame_done", 128'(frame_done), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      rst = 1'b0;

      // Input without start-of-frame is ignored from IDLE.
      run_table();

      // Contiguous frame, then the DONE state must ignore plain in_valid.
      run_frame(0, 0);
      run_table();

      // Same frame with random bubbles between pixels.
      run_frame(300, 3);

      // Abort at (2,5): that pixel becomes (0,0) of a new frame.
      win_count = 0;
      for (int r = 0; r < NR; r++) begin
         for (int c = 0; c < RS; c++) begin
            if ((r == 2) && (c == 5)) break;
            pix_cycle((r == 0) && (c == 0), 100, r, c);
         end
         if (r == 2) break;
      end
      win_count = 0;
      for (int r = 0; r < NR; r++) begin
         for (int c = 0; c < RS; c++) begin
            pix_cycle((r == 0) && (c == 0), 200, r, c);
         end
      end
      check("abort_window_count", 128'(win_count), 128'((RS-2)*(NR-2)));
      check("abort_busy", 128'(busy), 128'(0));

      // Asynchronous reset in STREAM right after accepting (3,3).
      for (int r = 0; r < NR; r++) begin
         for (int c = 0; c < RS; c++) begin
            if ((r == 3) && (c == 4)) break;
            pix_cycle((r == 0) && (c == 0), 400, r, c);
         end
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("arst_win_valid", 128'(win_valid), 128'(0));
      check("arst_win_pixels", 128'(win_pixels), 128'(0));
      check("arst_win_row", 128'(win_row), 128'(0));
      check("arst_win_col", 128'(win_col), 128'(0));
      check("arst_busy", 128'(busy), 128'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_frame(500, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_line_window_ctrl

// File: doc/line_window_ctrl.md
Name: line_window_ctrl

Overview:
Controller and window assembler for a pair of chained 1280-deep row buffers in the streaming image pipeline.
- Accepts a raster pixel stream and drives the shared clock-enable of both row buffers.
- Tracks column and row position, and assembles a 3x3 neighbourhood from the live pixel plus the two row-buffer outputs.
- Flags a valid window for every interior pixel; feeds the downstream convolution stage (Sobel/filter).

Parameters:
- ROW_SIZE, 1280, pixels per row; must match the row-buffer depth.
- NUM_ROWS, 960, rows per frame.
- PIXEL_SIZE, 12, bits per pixel.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_pixel is valid this cycle
- in_sof  input  1  qualifies in_pixel as pixel (0,0) of a new frame; meaningful only with in_valid
- in_pixel  input  PIXEL_SIZE  incoming raster pixel
- rb0_out  input  PIXEL_SIZE  output of row buffer 0 (one row ago)
- rb1_out  input  PIXEL_SIZE  output of row buffer 1 (two rows ago)
- rb_enable  output  1  clken to both row buffers
- rb_shiftin  output  PIXEL_SIZE  shiftin of row buffer 0; equals in_pixel
- win_valid  output  1  win_pixels holds a complete 3x3 window
- win_pixels  output  9*PIXEL_SIZE  window; slot k=3*dy+dx, dy0=top/oldest row, dx0=left/oldest column
- win_row  output  $clog2(NUM_ROWS)  row of window centre
- win_col  output  $clog2(ROW_SIZE)  column of window centre
- frame_done  output  1  one-cycle pulse after the last pixel of a frame
- busy  output  1  high in FILL or STREAM

Behaviour:
- Reset (asynchronous, rst=1):
  - State is IDLE.
  - Counters, column shift registers, win_valid, win_pixels, win_row, win_col and frame_done all 0.
- States: IDLE, FILL (rows 0-1), STREAM (rows >= 2), DONE.
- Accept condition: acc = in_valid & (in_sof | state in {FILL, STREAM}).
  - rb_enable = acc, combinational, same cycle.
  - rb_shiftin = in_pixel, combinational passthrough.
- Row-buffer contract: rb0_out/rb1_out present, in the same cycle as in_pixel, the samples that entered ROW_SIZE and 2*ROW_SIZE accepted cycles earlier.
- Transitions:
  - IDLE -> FILL on in_valid & in_sof. That pixel is (0,0); col/row then advance.
  - FILL -> STREAM on accepting pixel (1, ROW_SIZE-1).
  - STREAM -> DONE on accepting pixel (NUM_ROWS-1, ROW_SIZE-1); frame_done pulses the next cycle.
  - DONE -> FILL on in_valid & in_sof, which restarts the frame; otherwise inputs are ignored and rb_enable=0.
- Counters:
  - col wraps ROW_SIZE-1 -> 0 and increments row.
  - Both counters hold when acc=0.
- Column shift:
  - On acc, the {rb1_out, rb0_out, in_pixel} column shifts into dx=2 and the older columns move left.
  - Registers hold when acc=0.
- Window output, registered with 1-cycle latency:
  - win_valid=1 the cycle after accepting (r,c) with r>=2 and c>=2.
  - Centre is (r-1, c-1); windows never straddle rows.
  - win_valid=0 whenever no such accept occurred in the previous cycle (stall gives a bubble).
  - Exactly (ROW_SIZE-2)*(NUM_ROWS-2) windows per frame.
- in_sof mid-frame (FILL/STREAM):
  - Treated as (0,0) of a new frame; counters reset in the same cycle.
  - No window is emitted for the aborted frame's pending position; no frame_done pulse.
  - Stale row-buffer data is masked by the r>=2 rule.
- in_sof while acc with col/row not at (0,0) is the only abort path.
- Reset mid-frame: immediate return to IDLE with all outputs 0. Row-buffer contents are don't-care.
- busy=1 in FILL/STREAM, 0 in IDLE/DONE.

Decomposition:
- Package line_window_pkg holds:
  - typedef enum of states {IDLE, FILL, STREAM, DONE}
  - typedef pixel_t (PIXEL_SIZE bits)
  - typedef window_t (pixel_t [8:0])
  - constant WIN_DIM=3
- One sub-module: window_shift3, the three-column shift register with a hold enable, producing window_t.

Test Plan:
- ROW_SIZE=8, NUM_ROWS=4, pixel=8r+c, continuous in_valid, sof on pixel 0 -> first win_valid one cycle after pixel 18 accepted; win_pixels={0,1,2,8,9,10,16,17,18}; win_row=1, win_col=1.
- Same frame -> exactly 12 win_valid pulses; last window centre (2,6) with slot 8 = 31; frame_done one cycle after pixel 31; state DONE; rb_enable=0 for further in_valid without sof.
- Random in_valid gaps of 0-3 cycles -> identical window sequence; win_valid never high during a gap's following cycle; counters hold.
- in_sof at pixel (2,5) of frame 1 -> counters reset; no windows until new pixel (2,2); no frame_done for the aborted frame.
- Assert rst during STREAM at (3,4) -> outputs 0 asynchronously; a following sof frame produces 12 correct windows.
- in_valid without in_sof after reset -> rb_enable=0, no windows, busy=0.
